mux_scan_sequencer: RTL and testbench

- Sequential front-end that drives the address0/address1 select lines of the 4:1 structural multiplexer stage.
- Steps the select through a programmable subset of the four channels, waits DWELL cycles per channel for the mux output to settle, then samples the mux output.
- Assembles the sampled bits into a 4-bit frame, delivered downstream over a valid/ready handshake.

---
 rtl/mux_scan_sequencer_pkg.sv | 13 +
 rtl/mux_scan_sequencer_next_channel_finder.sv | 27 ++
 rtl/mux_scan_sequencer.sv | 134 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared constants and FSM state type for the mux scan sequencer and its helper logic.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_e;

endpackage : mux_pkg

// File: rtl/mux_scan_sequencer_next_channel_finder.sv
// Picks the next enabled channel: the lowest set mask bit when first_i is high,
// otherwise the lowest set bit strictly above the current channel.
module next_channel_finder
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [ADDR_W-1:0] cur_i,
  input  logic              first_i,
  output logic [ADDR_W-1:0] next_o,
  output logic              found_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    // Scan downwards so the lowest qualifying index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
        next_o  = ADDR_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule : next_channel_finder

// File: rtl/mux_scan_sequencer.sv
// Steps the 4:1 mux select through the enabled channels, dwells on each, samples
// mux_out and hands the assembled frame downstream over a valid/ready handshake.
module mux_scan_sequencer
  import mux_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] enable_mask,
  output logic              address0,
  output logic              address1,
  input  logic              mux_out,
  output logic              busy,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [NUM_CH-1:0] frame_data,
  output logic [NUM_CH-1:0] frame_mask
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;

  logic [ADDR_W-1:0]   first_ch;
  logic                first_found;
  logic [ADDR_W-1:0]   next_ch;
  logic                next_found;
  logic                start_ok;

  // First channel of a new scan comes straight from the incoming mask.
  next_channel_finder u_first_finder (
    .mask_i  (enable_mask),
    .cur_i   ('0),
    .first_i (1'b1),
    .next_o  (first_ch),
    .found_o (first_found)
  );

  next_channel_finder u_next_finder (
    .mask_i  (mask_q),
    .cur_i   (ch_q),
    .first_i (1'b0),
    .next_o  (next_ch),
    .found_o (next_found)
  );

  // An all-zero mask yields no first channel, so such a start is ignored.
  assign start_ok = start && first_found;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mask_d  = mask_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = SETTLE;
          mask_d  = enable_mask;
          data_d  = '0;
          ch_d    = first_ch;
          cnt_d   = CNT_RELOAD;
        end
      end

      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // mux_out is only looked at here, so X on other cycles never propagates.
          data_d[ch_q] = mux_out;
          if (next_found) begin
            ch_d  = next_ch;
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = OUT;
          end
        end
      end

      OUT: begin
        if (frame_ready) begin
          if (start_ok) begin
            state_d = SETTLE;
            mask_d  = enable_mask;
            data_d  = '0;
            ch_d    = first_ch;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  // Address parks at 00 in IDLE; in OUT it keeps the last sampled channel.
  assign {address1, address0} = (state_q == IDLE) ? '0 : ch_q;
  assign busy        = (state_q == SETTLE) || (state_q == OUT);
  assign frame_valid = (state_q == OUT);
  assign frame_data  = (state_q == OUT) ? data_q : '0;
  assign frame_mask  = (state_q == OUT) ? mask_q : '0;

endmodule : mux_scan_sequencer

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one instance with DWELL=2, one with DWELL=1,
// each driven by a behavioural 4:1 mux built from its address outputs.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start, frame_ready;
  logic [3:0] enable_mask, mux_in;
  logic       address0, address1, mux_out, busy, frame_valid;
  logic [3:0] frame_data, frame_mask;

  logic       start_b, frame_ready_b;
  logic [3:0] enable_mask_b, mux_in_b;
  logic       address0_b, address1_b, mux_out_b, busy_b, frame_valid_b;
  logic [3:0] frame_data_b, frame_mask_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mux_out   = mux_in[{address1, address0}];
  assign mux_out_b = mux_in_b[{address1_b, address0_b}];

  mux_scan_sequencer #(.DWELL(2), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .enable_mask (enable_mask),
    .address0    (address0),
    .address1    (address1),
    .mux_out     (mux_out),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_mask  (frame_mask)
  );

  mux_scan_sequencer #(.DWELL(1), .CNT_W(4)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .enable_mask (enable_mask_b),
    .address0    (address0_b),
    .address1    (address1_b),
    .mux_out     (mux_out_b),
    .busy        (busy_b),
    .frame_valid (frame_valid_b),
    .frame_ready (frame_ready_b),
    .frame_data  (frame_data_b),
    .frame_mask  (frame_mask_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"},  {30'd0, address1, address0}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, frame_valid}, 32'd0);
    check({tag, "_data"},  {28'd0, frame_data}, 32'd0);
    check({tag, "_mask"},  {28'd0, frame_mask}, 32'd0);
  endtask

  logic [1:0] addr_seq [8];

  initial begin
    rst_n = 1'b0;
    start = 1'b0; enable_mask = '0; mux_in = '0; frame_ready = 1'b0;
    start_b = 1'b0; enable_mask_b = '0; mux_in_b = '0; frame_ready_b = 1'b0;
    step(); step();
    check_idle("rst");
    check("rst_b_valid", {31'd0, frame_valid_b}, 32'd0);
    rst_n = 1'b1;
    step();

    // Full scan, mask 1111, inputs 1010.
    mux_in = 4'b1010; enable_mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0; enable_mask = '0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_addr%0d", i), {30'd0, address1, address0}, 32'(i / 2));
      check($sformatf("full_busy%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("full_nvalid%0d", i), {31'd0, frame_valid}, 32'd0);
      step();
    end
    check("full_valid", {31'd0, frame_valid}, 32'd1);
    check("full_data",  {28'd0, frame_data}, 32'b1010);
    check("full_mask",  {28'd0, frame_mask}, 32'b1111);
    check("full_hold_addr", {30'd0, address1, address0}, 32'd3);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check_idle("full_done");

    // Sparse scan, mask 0101, inputs 1111.
    mux_in = 4'b1111; enable_mask = 4'b0101; start = 1'b1;
    step();
    start = 1'b0; enable_mask = '0;
    addr_seq[0] = 2'd0; addr_seq[1] = 2'd0; addr_seq[2] = 2'd2; addr_seq[3] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sparse_addr%0d", i), {30'd0, address1, address0}, {30'd0, addr_seq[i]});
      check($sformatf("sparse_nvalid%0d", i), {31'd0, frame_valid}, 32'd0);
      step();
    end
    check("sparse_valid", {31'd0, frame_valid}, 32'd1);
    check("sparse_data",  {28'd0, frame_data}, 32'b0101);
    check("sparse_mask",  {28'd0, frame_mask}, 32'b0101);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check_idle("sparse_done");

    // Empty mask: start is ignored.
    start = 1'b1; enable_mask = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("empty_busy%0d", i),  {31'd0, busy}, 32'd0);
      check($sformatf("empty_valid%0d", i), {31'd0, frame_valid}, 32'd0);
    end
    start = 1'b0;

    // Backpressure then back-to-back restart.
    mux_in = 4'b0110; enable_mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0; enable_mask = '0;
    for (int i = 0; i < 8; i++) step();
    check("bp_valid", {31'd0, frame_valid}, 32'd1);
    check("bp_data0", {28'd0, frame_data}, 32'b0110);
    for (int i = 0; i < 5; i++) begin
      mux_in = ~mux_in;
      step();
      check($sformatf("bp_hold_valid%0d", i), {31'd0, frame_valid}, 32'd1);
      check($sformatf("bp_hold_data%0d", i),  {28'd0, frame_data}, 32'b0110);
      check($sformatf("bp_hold_mask%0d", i),  {28'd0, frame_mask}, 32'b1111);
    end
    mux_in = 4'b1000;
    frame_ready = 1'b1; start = 1'b1; enable_mask = 4'b1000;
    step();
    frame_ready = 1'b0; start = 1'b0; enable_mask = '0;
    check("b2b_busy",  {31'd0, busy}, 32'd1);
    check("b2b_valid", {31'd0, frame_valid}, 32'd0);
    check("b2b_addr",  {30'd0, address1, address0}, 32'd3);
    step();
    check("b2b_nvalid", {31'd0, frame_valid}, 32'd0);
    step();
    check("b2b_valid2", {31'd0, frame_valid}, 32'd1);
    check("b2b_data",   {28'd0, frame_data}, 32'b1000);
    check("b2b_mask",   {28'd0, frame_mask}, 32'b1000);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check_idle("b2b_done");

    // Reset in the middle of the second channel.
    mux_in = 4'b1010; enable_mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0; enable_mask = '0;
    step(); step();
    check("mid_addr", {30'd0, address1, address0}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle("mid_rst");
    mux_in = 4'b1001; enable_mask = 4'b1011; start = 1'b1;
    step();
    start = 1'b0; enable_mask = '0;
    addr_seq[0] = 2'd0; addr_seq[1] = 2'd0; addr_seq[2] = 2'd1;
    addr_seq[3] = 2'd1; addr_seq[4] = 2'd3; addr_seq[5] = 2'd3;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("post_addr%0d", i), {30'd0, address1, address0}, {30'd0, addr_seq[i]});
      check($sformatf("post_nvalid%0d", i), {31'd0, frame_valid}, 32'd0);
      step();
    end
    check("post_valid", {31'd0, frame_valid}, 32'd1);
    check("post_data",  {28'd0, frame_data}, 32'b1001);
    check("post_mask",  {28'd0, frame_mask}, 32'b1011);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;

    // DWELL=1 instance, mask 1001.
    mux_in_b = 4'b1001; enable_mask_b = 4'b1001; start_b = 1'b1;
    step();
    start_b = 1'b0; enable_mask_b = '0;
    check("d1_addr0",  {30'd0, address1_b, address0_b}, 32'd0);
    check("d1_busy0",  {31'd0, busy_b}, 32'd1);
    check("d1_nvalid0", {31'd0, frame_valid_b}, 32'd0);
    step();
    check("d1_addr1",  {30'd0, address1_b, address0_b}, 32'd3);
    check("d1_nvalid1", {31'd0, frame_valid_b}, 32'd0);
    step();
    check("d1_valid", {31'd0, frame_valid_b}, 32'd1);
    check("d1_data",  {28'd0, frame_data_b}, 32'b1001);
    check("d1_mask",  {28'd0, frame_mask_b}, 32'b1001);
    frame_ready_b = 1'b1;
    step();
    frame_ready_b = 1'b0;
    check("d1_idle_busy", {31'd0, busy_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_scan_sequencer
